// File: rtl/mmss_clock_ctrl.sv
// rtl/mmss_clock_ctrl.sv - MM:SS BCD clock controller with run/stop/set mode FSM
module mmss_clock_ctrl #(
  parameter bit START_RUN    = 1'b1,
  parameter int MIN_MAX_TENS = 5
) (
  input  logic       clk_50mhz,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic       blink,
  output logic       rollover,
  output logic       div_clear
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STOP    = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_t;

  localparam logic [3:0] MIN_TENS_LAST = 4'(MIN_MAX_TENS);
  localparam logic [3:0] SEC_TENS_LAST = 4'd5;
  localparam logic [3:0] ONES_LAST     = 4'd9;
  localparam state_t     RESET_STATE   = START_RUN ? ST_RUN : ST_STOP;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] min_tens_nxt;
  logic [3:0] min_ones_nxt;
  logic [3:0] sec_tens_nxt;
  logic [3:0] sec_ones_nxt;
  logic       blink_nxt;
  logic       rollover_nxt;
  logic       div_clear_nxt;

  // Incremented seconds/minutes fields, each wrapping independently to 00.
  // Comparisons use >= so a digit can never step past its BCD limit.
  logic       sec_wrap;
  logic       min_wrap;
  logic [3:0] sec_tens_inc;
  logic [3:0] sec_ones_inc;
  logic [3:0] min_tens_inc;
  logic [3:0] min_ones_inc;

  // Pure BCD increment of the two fields, shared by RUN counting and SET editing
  always_comb begin
    sec_wrap = (sec_ones >= ONES_LAST) && (sec_tens >= SEC_TENS_LAST);
    min_wrap = (min_ones >= ONES_LAST) && (min_tens >= MIN_TENS_LAST);

    if (sec_ones >= ONES_LAST) begin
      sec_ones_inc = 4'd0;
      sec_tens_inc = (sec_tens >= SEC_TENS_LAST) ? 4'd0 : sec_tens + 4'd1;
    end else begin
      sec_ones_inc = sec_ones + 4'd1;
      sec_tens_inc = sec_tens;
    end

    if (min_ones >= ONES_LAST) begin
      min_ones_inc = 4'd0;
      min_tens_inc = (min_tens >= MIN_TENS_LAST) ? 4'd0 : min_tens + 4'd1;
    end else begin
      min_ones_inc = min_ones + 4'd1;
      min_tens_inc = min_tens;
    end
  end

  // Next-state, next-time and next-flag decode for the mode FSM
  always_comb begin
    state_nxt     = state;
    min_tens_nxt  = min_tens;
    min_ones_nxt  = min_ones;
    sec_tens_nxt  = sec_tens;
    sec_ones_nxt  = sec_ones;
    blink_nxt     = 1'b0;
    rollover_nxt  = 1'b0;
    div_clear_nxt = 1'b0;

    unique case (state)
      ST_RUN: begin
        // A tick in the same cycle as btn_mode still lands before leaving RUN.
        if (tick_1hz) begin
          sec_ones_nxt = sec_ones_inc;
          sec_tens_nxt = sec_tens_inc;
          if (sec_wrap) begin
            min_ones_nxt = min_ones_inc;
            min_tens_nxt = min_tens_inc;
            rollover_nxt = min_wrap;
          end
        end
        if (btn_mode) begin
          state_nxt = ST_STOP;
        end
      end

      ST_STOP: begin
        if (btn_mode) begin
          state_nxt = ST_SET_MIN;
        end else if (btn_inc) begin
          min_tens_nxt = 4'd0;
          min_ones_nxt = 4'd0;
          sec_tens_nxt = 4'd0;
          sec_ones_nxt = 4'd0;
        end
      end

      ST_SET_MIN: begin
        if (btn_mode) begin
          state_nxt = ST_SET_SEC;
        end else begin
          blink_nxt = blink ^ tick_1hz;
          if (btn_inc) begin
            min_ones_nxt = min_ones_inc;
            min_tens_nxt = min_tens_inc;
          end
        end
      end

      ST_SET_SEC: begin
        if (btn_mode) begin
          state_nxt     = ST_RUN;
          div_clear_nxt = 1'b1;
        end else begin
          blink_nxt = blink ^ tick_1hz;
          if (btn_inc) begin
            sec_ones_nxt = sec_ones_inc;
            sec_tens_nxt = sec_tens_inc;
          end
        end
      end

      default: begin
        state_nxt = RESET_STATE;
      end
    endcase
  end

  // Register state, time digits and one-cycle flags; reset clears in-flight pulses
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_STATE;
      min_tens  <= 4'd0;
      min_ones  <= 4'd0;
      sec_tens  <= 4'd0;
      sec_ones  <= 4'd0;
      blink     <= 1'b0;
      rollover  <= 1'b0;
      div_clear <= 1'b0;
    end else begin
      state     <= state_nxt;
      min_tens  <= min_tens_nxt;
      min_ones  <= min_ones_nxt;
      sec_tens  <= sec_tens_nxt;
      sec_ones  <= sec_ones_nxt;
      blink     <= blink_nxt;
      rollover  <= rollover_nxt;
      div_clear <= div_clear_nxt;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_mmss_clock_ctrl.sv
// tb/tb_mmss_clock_ctrl.sv - directed self-checking bench for mmss_clock_ctrl
module tb_mmss_clock_ctrl;

  logic       clk_50mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       tick_1hz  = 1'b0;
  logic       btn_mode  = 1'b0;
  logic       btn_inc   = 1'b0;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] mode;
  logic       blink;
  logic       rollover;
  logic       div_clear;
  logic [15:0] time_bcd;

  int checks = 0;
  int errors = 0;

  assign time_bcd = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk_50mhz = ~clk_50mhz;

  mmss_clock_ctrl #(
    .START_RUN   (1'b1),
    .MIN_MAX_TENS(5)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .reset_n  (reset_n),
    .tick_1hz (tick_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .mode     (mode),
    .blink    (blink),
    .rollover (rollover),
    .div_clear(div_clear)
  );

  // Drive inputs for one cycle starting 1 ns after an edge; returns 1 ns after the next edge.
  task automatic step(input logic t_in, input logic m_in, input logic i_in);
    tick_1hz = t_in;
    btn_mode = m_in;
    btn_inc  = i_in;
    @(posedge clk_50mhz);
    #1;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_50mhz);
    #1;
    reset_n = 1'b0;
    @(posedge clk_50mhz);
    #1;
    reset_n = 1'b1;
  endtask

  // Reset, then load m:s (decimal counts of increments) through STOP/SET_MIN/SET_SEC back into RUN.
  task automatic preload(input int m, input int s);
    do_reset();
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    for (int k = 0; k < m; k++) step(0, 0, 1);
    step(0, 1, 0);
    for (int k = 0; k < s; k++) step(0, 0, 1);
    step(0, 1, 0);
  endtask

  task automatic test_reset();
    @(posedge clk_50mhz);
    #1;
    reset_n = 1'b0;
    #2;
    checks++;
    if (time_bcd !== 16'h0000) begin
      errors++; $display("FAIL reset_time: got %h expected 0000", time_bcd);
    end
    checks++;
    if ({mode, blink, rollover, div_clear} !== 5'b00000) begin
      errors++; $display("FAIL reset_flags: got mode=%0d blink=%b roll=%b divclr=%b expected 0 0 0 0",
                         mode, blink, rollover, div_clear);
    end
    @(posedge clk_50mhz);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0);
      checks++;
      if (div_clear !== 1'b0 || mode !== 2'd0) begin
        errors++; $display("FAIL reset_to_run: got divclr=%b mode=%0d expected 0 0", div_clear, mode);
      end
    end
  endtask

  task automatic test_run_count();
    logic seen_roll;
    seen_roll = 1'b0;
    do_reset();
    for (int n = 1; n <= 61; n++) begin
      step(1, 0, 0);
      if (rollover) seen_roll = 1'b1;
      if (n == 10) begin
        checks++;
        if (time_bcd !== 16'h0010) begin
          errors++; $display("FAIL run_10s: got %h expected 0010", time_bcd);
        end
      end
      if (n == 60) begin
        checks++;
        if (time_bcd !== 16'h0100) begin
          errors++; $display("FAIL run_60s: got %h expected 0100", time_bcd);
        end
      end
      for (int k = 0; k < 3; k++) begin
        step(0, 0, 0);
        if (rollover) seen_roll = 1'b1;
      end
    end
    checks++;
    if (time_bcd !== 16'h0101 || mode !== 2'd0) begin
      errors++; $display("FAIL run_61s: got %h mode=%0d expected 0101 mode=0", time_bcd, mode);
    end
    checks++;
    if (seen_roll !== 1'b0) begin
      errors++; $display("FAIL run_no_roll: got %b expected 0", seen_roll);
    end
  endtask

  task automatic test_rollover();
    preload(59, 58);
    checks++;
    if (div_clear !== 1'b1 || mode !== 2'd0 || time_bcd !== 16'h5958) begin
      errors++; $display("FAIL resume: got divclr=%b mode=%0d time=%h expected 1 0 5958",
                         div_clear, mode, time_bcd);
    end
    step(0, 0, 0);
    checks++;
    if (div_clear !== 1'b0) begin
      errors++; $display("FAIL divclr_width: got %b expected 0", div_clear);
    end
    step(1, 0, 0);
    checks++;
    if (time_bcd !== 16'h5959 || rollover !== 1'b0) begin
      errors++; $display("FAIL tick_5959: got %h roll=%b expected 5959 0", time_bcd, rollover);
    end
    step(1, 0, 0);
    checks++;
    if (time_bcd !== 16'h0000 || rollover !== 1'b1) begin
      errors++; $display("FAIL wrap: got %h roll=%b expected 0000 1", time_bcd, rollover);
    end
    step(0, 0, 0);
    checks++;
    if (rollover !== 1'b0) begin
      errors++; $display("FAIL roll_width: got %b expected 0", rollover);
    end
  endtask

  task automatic test_stop();
    do_reset();
    for (int k = 0; k < 10; k++) step(1, 0, 0);
    step(0, 1, 0);
    checks++;
    if (mode !== 2'd1 || time_bcd !== 16'h0010) begin
      errors++; $display("FAIL stop_enter: got mode=%0d time=%h expected 1 0010", mode, time_bcd);
    end
    for (int k = 0; k < 5; k++) step(1, 0, 0);
    checks++;
    if (time_bcd !== 16'h0010) begin
      errors++; $display("FAIL stop_hold: got %h expected 0010", time_bcd);
    end
    step(0, 0, 1);
    checks++;
    if (time_bcd !== 16'h0000 || rollover !== 1'b0 || mode !== 2'd1) begin
      errors++; $display("FAIL stop_clear: got %h roll=%b mode=%0d expected 0000 0 1",
                         time_bcd, rollover, mode);
    end
  endtask

  task automatic test_set_min();
    logic [15:0] exp_time [3];
    exp_time[0] = 16'h5930;
    exp_time[1] = 16'h0030;
    exp_time[2] = 16'h0130;
    do_reset();
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    for (int k = 0; k < 30; k++) step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    for (int k = 0; k < 58; k++) step(0, 0, 1);
    checks++;
    if (time_bcd !== 16'h5830 || mode !== 2'd2) begin
      errors++; $display("FAIL setmin_load: got %h mode=%0d expected 5830 2", time_bcd, mode);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1);
      checks++;
      if (time_bcd !== exp_time[k] || mode !== 2'd2) begin
        errors++; $display("FAIL setmin_inc%0d: got %h mode=%0d expected %h 2",
                           k, time_bcd, mode, exp_time[k]);
      end
    end
    step(1, 0, 0);
    checks++;
    if (blink !== 1'b1 || time_bcd !== 16'h0130) begin
      errors++; $display("FAIL blink_on: got blink=%b time=%h expected 1 0130", blink, time_bcd);
    end
    step(1, 0, 0);
    checks++;
    if (blink !== 1'b0) begin
      errors++; $display("FAIL blink_off: got %b expected 0", blink);
    end
    step(1, 0, 1);
    checks++;
    if (blink !== 1'b1 || time_bcd !== 16'h0230) begin
      errors++; $display("FAIL tick_inc: got blink=%b time=%h expected 1 0230", blink, time_bcd);
    end
    step(0, 1, 1);
    checks++;
    if (mode !== 2'd3 || time_bcd !== 16'h0230 || blink !== 1'b0) begin
      errors++; $display("FAIL mode_beats_inc: got mode=%0d time=%h blink=%b expected 3 0230 0",
                         mode, time_bcd, blink);
    end
    for (int k = 0; k < 30; k++) step(0, 0, 1);
    checks++;
    if (time_bcd !== 16'h0200) begin
      errors++; $display("FAIL setsec_wrap: got %h expected 0200", time_bcd);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 9; k++) step(1, 0, 0);
    step(1, 1, 0);
    checks++;
    if (time_bcd !== 16'h0010 || mode !== 2'd1) begin
      errors++; $display("FAIL tick_and_mode: got %h mode=%0d expected 0010 1", time_bcd, mode);
    end
  endtask

  task automatic test_reset_mid();
    preload(59, 59);
    step(1, 0, 0);
    checks++;
    if (rollover !== 1'b1) begin
      errors++; $display("FAIL mid_roll_pre: got %b expected 1", rollover);
    end
    reset_n = 1'b0;
    @(posedge clk_50mhz);
    #1;
    checks++;
    if (rollover !== 1'b0 || time_bcd !== 16'h0000 || mode !== 2'd0 || div_clear !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got roll=%b time=%h mode=%0d divclr=%b expected 0 0000 0 0",
                         rollover, time_bcd, mode, div_clear);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_rollover();
    test_stop();
    test_set_min();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
